seq_delay_checker: RTL and testbench

SEQ_DELAY_CHECKER -- requirements
Module: seq_delay_checker

---
 rtl/seq_delay_checker.sv | 82 ++++++++
 tb/tb_seq_delay_checker.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/seq_delay_checker.sv
// Sequence checker for "a, then b exactly DELAY edges later", one overlapping attempt per edge.
// It pulses pass/fail events and keeps saturating pass and fail counters.
module seq_delay_checker #(
   parameter int unsigned DELAY = 2,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clear,
   input  logic             a,
   input  logic             b,
   output logic             pass,
   output logic             fail_imm,
   output logic             fail_dly,
   output logic             busy,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] fail_cnt
);

   localparam logic [CNT_W-1:0] CntMax = '1;

   logic [DELAY-1:0] pending_q, pending_d;
   logic             pass_d, fail_imm_d, fail_dly_d;
   logic [CNT_W-1:0] pass_cnt_d, fail_cnt_d;
   logic [1:0]       fail_inc;
   logic [CNT_W:0]   fail_sum;
   logic             matured;

   // The oldest pending bit marks an attempt that started DELAY edges ago.
   assign matured = pending_q[DELAY-1];
   assign busy    = |pending_q;

   always_comb begin
      pending_d  = '0;
      pass_d     = 1'b0;
      fail_imm_d = 1'b0;
      fail_dly_d = 1'b0;
      pass_cnt_d = pass_cnt;
      fail_cnt_d = fail_cnt;
      fail_inc   = '0;
      fail_sum   = '0;
      if (!clear) begin
         for (int i = int'(DELAY) - 1; i > 0; i--) begin
            pending_d[i] = pending_q[i-1];
         end
         pending_d[0] = en & a;
         pass_d       = matured & b;
         fail_dly_d   = matured & ~b;
         fail_imm_d   = en & ~a;
         if (pass_d && (pass_cnt != CntMax)) begin
            pass_cnt_d = pass_cnt + CNT_W'(1);
         end
         // Extra carry bit catches both single and double increments that overflow.
         fail_inc   = {1'b0, fail_imm_d} + {1'b0, fail_dly_d};
         fail_sum   = {1'b0, fail_cnt} + (CNT_W+1)'(fail_inc);
         fail_cnt_d = fail_sum[CNT_W] ? CntMax : fail_sum[CNT_W-1:0];
      end else begin
         pass_cnt_d = '0;
         fail_cnt_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending_q <= '0;
         pass      <= 1'b0;
         fail_imm  <= 1'b0;
         fail_dly  <= 1'b0;
         pass_cnt  <= '0;
         fail_cnt  <= '0;
      end else begin
         pending_q <= pending_d;
         pass      <= pass_d;
         fail_imm  <= fail_imm_d;
         fail_dly  <= fail_dly_d;
         pass_cnt  <= pass_cnt_d;
         fail_cnt  <= fail_cnt_d;
      end
   end

endmodule

// File: tb/tb_seq_delay_checker.sv
// Directed bench for seq_delay_checker (DELAY=2, CNT_W=4), with hand-computed expectations.
module tb_seq_delay_checker;

   localparam int unsigned DELAY = 2;
   localparam int unsigned CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             en = 1'b0;
   logic             clear = 1'b0;
   logic             a = 1'b0;
   logic             b = 1'b0;
   logic             pass, fail_imm, fail_dly, busy;
   logic [CNT_W-1:0] pass_cnt, fail_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   seq_delay_checker #(
      .DELAY(DELAY),
      .CNT_W(CNT_W)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .clear   (clear),
      .a       (a),
      .b       (b),
      .pass    (pass),
      .fail_imm(fail_imm),
      .fail_dly(fail_dly),
      .busy    (busy),
      .pass_cnt(pass_cnt),
      .fail_cnt(fail_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Apply inputs, take one rising edge, then settle 1 time unit before sampling.
   task automatic step(input logic e, input logic aa, input logic bb, input logic cl);
      en    = e;
      a     = aa;
      b     = bb;
      clear = cl;
      @(posedge clk);
      #1;
   endtask

   task automatic do_clear();
      step(1'b0, 1'b0, 1'b0, 1'b1);
      clear = 1'b0;
   endtask

   initial begin
      // Reset state
      #2;
      check("rst_pass", 32'(pass), 0);
      check("rst_fimm", 32'(fail_imm), 0);
      check("rst_fdly", 32'(fail_dly), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_pcnt", 32'(pass_cnt), 0);
      check("rst_fcnt", 32'(fail_cnt), 0);
      @(negedge clk);
      rst = 1'b0;

      // Edge1 attempt matures at edge3 and sees b high
      step(1, 1, 0, 0);
      check("t1_e1_pass", 32'(pass), 0);
      check("t1_e1_busy", 32'(busy), 1);
      step(1, 1, 0, 0);
      check("t1_e2_pass", 32'(pass), 0);
      check("t1_e2_fdly", 32'(fail_dly), 0);
      step(1, 1, 1, 0);
      check("t1_e3_pass", 32'(pass), 1);
      check("t1_e3_fdly", 32'(fail_dly), 0);
      check("t1_e3_pcnt", 32'(pass_cnt), 1);
      check("t1_e3_fcnt", 32'(fail_cnt), 0);
      do_clear();
      check("t1_clr_pcnt", 32'(pass_cnt), 0);
      check("t1_clr_busy", 32'(busy), 0);

      // Delayed failure
      step(1, 1, 0, 0);
      step(0, 0, 0, 0);
      check("t2_e2_busy", 32'(busy), 1);
      check("t2_e2_fimm", 32'(fail_imm), 0);
      step(0, 0, 0, 0);
      check("t2_e3_fdly", 32'(fail_dly), 1);
      check("t2_e3_pass", 32'(pass), 0);
      check("t2_e3_fcnt", 32'(fail_cnt), 1);
      check("t2_e3_pcnt", 32'(pass_cnt), 0);
      check("t2_e3_busy", 32'(busy), 0);
      do_clear();

      // Immediate and delayed failure on the same edge
      step(1, 1, 0, 0);
      step(0, 0, 0, 0);
      step(1, 0, 0, 0);
      check("t3_fimm", 32'(fail_imm), 1);
      check("t3_fdly", 32'(fail_dly), 1);
      check("t3_pass", 32'(pass), 0);
      check("t3_fcnt", 32'(fail_cnt), 2);
      do_clear();

      // en low: in-flight attempt still matures, no immediate failures
      step(1, 1, 0, 0);
      step(0, 0, 0, 0);
      check("t4_e2_fimm", 32'(fail_imm), 0);
      step(0, 0, 1, 0);
      check("t4_e3_pass", 32'(pass), 1);
      check("t4_e3_fimm", 32'(fail_imm), 0);
      step(0, 0, 0, 0);
      check("t4_e4_fdly", 32'(fail_dly), 0);
      step(0, 0, 0, 0);
      check("t4_e5_busy", 32'(busy), 0);
      check("t4_e5_pcnt", 32'(pass_cnt), 1);
      check("t4_e5_fcnt", 32'(fail_cnt), 0);
      do_clear();

      // clear wins over en and drops the pending attempt
      step(1, 0, 0, 0);
      check("t5_pre_fcnt", 32'(fail_cnt), 1);
      step(1, 1, 0, 0);
      step(1, 1, 1, 1);
      check("t5_clr_fcnt", 32'(fail_cnt), 0);
      check("t5_clr_busy", 32'(busy), 0);
      check("t5_clr_fimm", 32'(fail_imm), 0);
      step(0, 0, 1, 0);
      check("t5_e3_pass", 32'(pass), 0);
      check("t5_e3_fdly", 32'(fail_dly), 0);
      check("t5_e3_pcnt", 32'(pass_cnt), 0);

      // Pass counter saturation: after edge k (k>=3) there have been k-2 passes
      for (int k = 1; k <= 20; k++) begin
         step(1, 1, 1, 0);
         if (k == 16) check("t6_pcnt_14", 32'(pass_cnt), 14);
         if (k == 17) check("t6_pcnt_15", 32'(pass_cnt), 15);
      end
      check("t6_pcnt_sat", 32'(pass_cnt), 15);
      check("t6_fcnt", 32'(fail_cnt), 0);
      check("t6_pass", 32'(pass), 1);
      do_clear();

      // Fail counter: 14 then a double-fail edge saturates to 15
      for (int k = 0; k < 13; k++) step(1, 0, 0, 0);
      check("t7_fcnt_13", 32'(fail_cnt), 13);
      step(1, 1, 0, 0);
      step(1, 0, 0, 0);
      check("t7_fcnt_14", 32'(fail_cnt), 14);
      step(1, 0, 0, 0);
      check("t7_dbl_fimm", 32'(fail_imm), 1);
      check("t7_dbl_fdly", 32'(fail_dly), 1);
      check("t7_fcnt_sat", 32'(fail_cnt), 15);
      step(1, 0, 0, 0);
      check("t7_fcnt_hold", 32'(fail_cnt), 15);
      do_clear();

      // Asynchronous reset mid-operation discards in-flight attempts
      step(1, 0, 0, 0);
      step(1, 1, 0, 0);
      step(1, 1, 0, 0);
      check("t8_pre_busy", 32'(busy), 1);
      check("t8_pre_fcnt", 32'(fail_cnt), 1);
      #2;
      rst = 1'b1;
      #1;
      check("t8_rst_busy", 32'(busy), 0);
      check("t8_rst_fcnt", 32'(fail_cnt), 0);
      check("t8_rst_fimm", 32'(fail_imm), 0);
      #1;
      rst = 1'b0;
      step(0, 0, 1, 0);
      check("t8_e3_pass", 32'(pass), 0);
      check("t8_e3_fdly", 32'(fail_dly), 0);
      step(0, 0, 1, 0);
      check("t8_e4_pass", 32'(pass), 0);
      check("t8_e4_pcnt", 32'(pass_cnt), 0);
      check("t8_e4_busy", 32'(busy), 0);
      step(1, 1, 0, 0);
      check("t8_new_busy", 32'(busy), 1);
      step(0, 0, 0, 0);
      step(0, 0, 1, 0);
      check("t8_new_pass", 32'(pass), 1);
      check("t8_new_pcnt", 32'(pass_cnt), 1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
